// File: rtl/snn_ctrl_pkg.sv
// snn_ctrl_pkg: shared scheduler state encoding and width helper
package snn_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, WAIT_IN, START, RUN, STEP_END} sched_state_t;

    // Index width for n values, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart from zero (combined with en the cycle counts as 1)
//   en       : count this cycle
//   q        : current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    logic [W-1:0] base;

    assign base = clr ? '0 : q;

    always_ff @(posedge clk)
        q <= rst ? '0 : (en && base != '1) ? base + W'(1) : base;

endmodule

// File: rtl/snn_timestep_scheduler.sv
// snn_timestep_scheduler: sequences one spiking conv layer over time steps and channel groups
//   input_avail / input_consume : upstream spike-frame handshake (level in, pulse out)
//   layer_start / layer_done    : one datapath pass per (ts_idx, oc_grp)
//   mem_clear, mem_bank_sel     : membrane zeroing on step 0, ping-pong bank = ts_idx[0]
//   layer_avail, frame_done     : per-step and per-frame completion pulses
//   busy, spurious_done         : activity level, sticky stray-done flag
//   frame_cycles                : saturating cycle count of the last/current frame
module snn_timestep_scheduler
    import snn_ctrl_pkg::*;
#(
    parameter  int TIME_STEPS      = 25,
    parameter  int OUTPUT_CHANNELS = 64,
    parameter  int PE_LANES        = 16,
    parameter  int CYC_W           = 32,
    localparam int TS_W            = clog2_min1(TIME_STEPS),
    localparam int GRP_W           = clog2_min1(OUTPUT_CHANNELS / PE_LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input_avail,
    output logic             input_consume,
    output logic             layer_start,
    input  logic             layer_done,
    output logic [TS_W-1:0]  ts_idx,
    output logic [GRP_W-1:0] oc_grp,
    output logic             mem_clear,
    output logic             mem_bank_sel,
    output logic             layer_avail,
    output logic             frame_done,
    output logic             busy,
    output logic             spurious_done,
    output logic [CYC_W-1:0] frame_cycles
);

    localparam int GRP_N = OUTPUT_CHANNELS / PE_LANES;

    if (OUTPUT_CHANNELS % PE_LANES != 0) begin : g_cfg_check
        $error("OUTPUT_CHANNELS must be a multiple of PE_LANES");
    end

    sched_state_t state;
    logic         last_grp;
    logic         last_ts;
    logic         go;

    assign last_grp = oc_grp == GRP_W'(GRP_N - 1);
    assign last_ts  = ts_idx == TS_W'(TIME_STEPS - 1);
    assign go       = state == IDLE && input_avail;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ts_idx        <= '0;
            oc_grp        <= '0;
            spurious_done <= 1'b0;
        end else begin
            if (layer_done && state != RUN)
                spurious_done <= 1'b1;
            case (state)
                IDLE: if (input_avail) begin
                    ts_idx <= '0;
                    oc_grp <= '0;
                    state  <= START;
                end
                WAIT_IN: if (input_avail) state <= START;
                START: state <= RUN;
                RUN: if (layer_done) begin
                    if (last_grp) begin
                        state <= STEP_END;
                    end else begin
                        oc_grp <= oc_grp + GRP_W'(1);
                        state  <= START;
                    end
                end
                STEP_END: begin
                    oc_grp <= '0;
                    ts_idx <= last_ts ? '0 : ts_idx + TS_W'(1);
                    state  <= last_ts ? IDLE : WAIT_IN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode: every output depends only on registered state and indices
    assign layer_start   = state == START;
    assign mem_clear     = layer_start && ts_idx == '0;
    assign layer_avail   = state == STEP_END;
    assign input_consume = layer_avail;
    assign frame_done    = layer_avail && last_ts;
    assign busy          = state != IDLE;
    assign mem_bank_sel  = ts_idx[0];

    // The cycle that leaves IDLE counts as the first cycle of the frame
    sat_counter #(.W(CYC_W)) u_frame_cycles (
        .clk (clk),
        .rst (rst),
        .clr (go),
        .en  (busy || go),
        .q   (frame_cycles)
    );

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// tb_snn_timestep_scheduler: model-checked bench over three scheduler configurations
module tb_snn_timestep_scheduler;

    localparam int G = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] av = '0, dn = '0, rs = '1, inj = '0;

    logic ls_a, mc_a, bank_a, la_a, ic_a, fd_a, busy_a, sp_a;
    logic [1:0] ts_a, grp_a;
    logic [31:0] fc_a;
    logic ls_b, mc_b, bank_b, la_b, ic_b, fd_b, busy_b, sp_b;
    logic [0:0] ts_b;
    logic [1:0] grp_b;
    logic [31:0] fc_b;
    logic ls_c, mc_c, bank_c, la_c, ic_c, fd_c, busy_c, sp_c;
    logic [0:0] ts_c;
    logic [1:0] grp_c;
    logic [3:0] fc_c;

    snn_timestep_scheduler #(.TIME_STEPS(3), .OUTPUT_CHANNELS(64), .PE_LANES(16), .CYC_W(32)) u_a (
        .clk(clk), .rst(rs[0]), .input_avail(av[0]), .input_consume(ic_a), .layer_start(ls_a),
        .layer_done(dn[0]), .ts_idx(ts_a), .oc_grp(grp_a), .mem_clear(mc_a), .mem_bank_sel(bank_a),
        .layer_avail(la_a), .frame_done(fd_a), .busy(busy_a), .spurious_done(sp_a), .frame_cycles(fc_a));
    snn_timestep_scheduler #(.TIME_STEPS(2), .OUTPUT_CHANNELS(64), .PE_LANES(16), .CYC_W(32)) u_b (
        .clk(clk), .rst(rs[1]), .input_avail(av[1]), .input_consume(ic_b), .layer_start(ls_b),
        .layer_done(dn[1]), .ts_idx(ts_b), .oc_grp(grp_b), .mem_clear(mc_b), .mem_bank_sel(bank_b),
        .layer_avail(la_b), .frame_done(fd_b), .busy(busy_b), .spurious_done(sp_b), .frame_cycles(fc_b));
    snn_timestep_scheduler #(.TIME_STEPS(1), .OUTPUT_CHANNELS(64), .PE_LANES(16), .CYC_W(4)) u_c (
        .clk(clk), .rst(rs[2]), .input_avail(av[2]), .input_consume(ic_c), .layer_start(ls_c),
        .layer_done(dn[2]), .ts_idx(ts_c), .oc_grp(grp_c), .mem_clear(mc_c), .mem_bank_sel(bank_c),
        .layer_avail(la_c), .frame_done(fd_c), .busy(busy_c), .spurious_done(sp_c), .frame_cycles(fc_c));

    typedef struct packed {
        logic        ls, mc, bank, la, ic, fd, busy, sp;
        logic [31:0] ts, grp;
        logic [63:0] fc;
    } outs_t;
    outs_t o [3];

    always_comb begin
        o[0] = '{ls_a, mc_a, bank_a, la_a, ic_a, fd_a, busy_a, sp_a, 32'(ts_a), 32'(grp_a), 64'(fc_a)};
        o[1] = '{ls_b, mc_b, bank_b, la_b, ic_b, fd_b, busy_b, sp_b, 32'(ts_b), 32'(grp_b), 64'(fc_b)};
        o[2] = '{ls_c, mc_c, bank_c, la_c, ic_c, fd_c, busy_c, sp_c, 32'(ts_c), 32'(grp_c), 64'(fc_c)};
    end

    int     tsteps [3] = '{3, 2, 1};
    int     dly    [3] = '{5, 1, 20};
    longint mx     [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};

    int checks = 0, errors = 0, cyc = 0;
    bit en = 1'b0;
    int done_at [3] = '{-1, -1, -1};

    // Model: a frame is a run of passes; ts/grp follow from the count of completed passes
    bit     act [3] = '{0, 0, 0}, in_pass [3] = '{0, 0, 0}, waiting [3] = '{0, 0, 0}, spur [3] = '{0, 0, 0};
    int     passes [3] = '{0, 0, 0}, start_at [3] = '{-1, -1, -1}, end_at [3] = '{-1, -1, -1}, b [3] = '{0, 0, 0};
    longint fc [3] = '{0, 0, 0};

    int n_ls [3] = '{0, 0, 0}, n_mc [3] = '{0, 0, 0}, n_la [3] = '{0, 0, 0}, n_ic [3] = '{0, 0, 0};
    int n_fd [3] = '{0, 0, 0}, n_hit [3] = '{0, 0, 0};
    int first_bank [3] = '{0, 0, 0}, last_bank [3] = '{0, 0, 0}, last_pos [3] = '{0, 0, 0};

    task automatic chk(input string nm, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic longint minl(input longint x, input longint y);
        return x < y ? x : y;
    endfunction

    // Datapath stub: done comes dly cycles after each observed start, plus injected strays
    initial forever begin
        @(posedge clk);
        cyc++;
        #3;
        for (int k = 0; k < 3; k++) dn[k] = (cyc == done_at[k]) || inj[k];
    end

    initial begin
        int pe, et, eg;
        bit els, eend, run;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                eend = act[k] && cyc == end_at[k];
                els  = act[k] && cyc == start_at[k];
                pe   = eend ? passes[k] - 1 : passes[k];
                et   = pe / G;
                eg   = pe % G;
                if (en) begin
                    chk($sformatf("u%0d.layer_start", k), o[k].ls, els);
                    chk($sformatf("u%0d.mem_clear", k), o[k].mc, els && et == 0);
                    chk($sformatf("u%0d.ts_idx", k), o[k].ts, et);
                    chk($sformatf("u%0d.oc_grp", k), o[k].grp, eg);
                    chk($sformatf("u%0d.mem_bank_sel", k), o[k].bank, et % 2);
                    chk($sformatf("u%0d.layer_avail", k), o[k].la, eend);
                    chk($sformatf("u%0d.input_consume", k), o[k].ic, eend);
                    chk($sformatf("u%0d.frame_done", k), o[k].fd, eend && et == tsteps[k] - 1);
                    chk($sformatf("u%0d.busy", k), o[k].busy, act[k]);
                    chk($sformatf("u%0d.spurious_done", k), o[k].sp, spur[k]);
                    chk($sformatf("u%0d.frame_cycles", k), o[k].fc, act[k] ? minl(cyc - b[k], mx[k]) : fc[k]);
                end
                if (o[k].ls) begin
                    n_ls[k]++;
                    if (n_ls[k] == 1) first_bank[k] = int'(o[k].bank);
                    last_bank[k] = int'(o[k].bank);
                    last_pos[k] = int'(o[k].ts) * G + int'(o[k].grp);
                    if (o[k].ts == 1 && o[k].grp == 2) n_hit[k]++;
                    done_at[k] = cyc + dly[k];
                end
                if (o[k].mc) n_mc[k]++;
                if (o[k].la) n_la[k]++;
                if (o[k].ic) n_ic[k]++;
                if (o[k].fd) n_fd[k]++;
                if (rs[k]) begin
                    act[k] = 0; in_pass[k] = 0; waiting[k] = 0; spur[k] = 0;
                    passes[k] = 0; start_at[k] = -1; end_at[k] = -1; fc[k] = 0;
                end else begin
                    run = act[k] && in_pass[k] && cyc > start_at[k];
                    if (dn[k] && !run) spur[k] = 1;
                    if (!act[k]) begin
                        if (av[k]) begin
                            act[k] = 1; b[k] = cyc; passes[k] = 0; start_at[k] = cyc + 1; in_pass[k] = 1;
                        end
                    end else if (run && dn[k]) begin
                        passes[k]++;
                        in_pass[k] = 0;
                        if (passes[k] % G != 0) begin
                            start_at[k] = cyc + 1; in_pass[k] = 1;
                        end else end_at[k] = cyc + 1;
                    end else if (eend) begin
                        if (et == tsteps[k] - 1) begin
                            act[k] = 0; passes[k] = 0; fc[k] = minl(cyc - b[k] + 1, mx[k]);
                        end else waiting[k] = 1;
                    end else if (waiting[k] && av[k]) begin
                        waiting[k] = 0; start_at[k] = cyc + 1; in_pass[k] = 1;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
        #1;
    endtask

    function automatic int cnt(input int k, input int w);
        return w == 0 ? n_la[k] : w == 1 ? n_fd[k] : n_hit[k];
    endfunction

    task automatic wait_ev(input int k, input int w, input int budget);
        int base = cnt(k, w);
        int n = 0;
        while (cnt(k, w) == base && n < budget) begin
            step();
            n++;
        end
        if (cnt(k, w) == base) begin
            checks++;
            errors++;
            $display("FAIL timeout u%0d event %0d: got nothing within %0d cycles", k, w, budget);
        end
    endtask

    initial begin
        int b_ls, b_mc, b_la, b_ic, b_fd, b_hit;
        step();
        en = 1'b1;
        step();
        step();
        rs = '0;
        samp();
        chk("reset.busy", o[0].busy, 0);
        chk("reset.ts_idx", o[0].ts, 0);
        chk("reset.frame_cycles", o[0].fc, 0);
        chk("reset.spurious_done", o[0].sp, 0);
        chk("reset.layer_start", o[1].ls, 0);

        // Full frame, input held high, done 5 cycles after each start
        step();
        b_ls = n_ls[0]; b_mc = n_mc[0]; b_la = n_la[0]; b_ic = n_ic[0]; b_fd = n_fd[0];
        av[0] = 1'b1;
        wait_ev(0, 1, 1000);
        av[0] = 1'b0;
        samp();
        chk("frame.starts", n_ls[0] - b_ls, 12);
        chk("frame.mem_clears", n_mc[0] - b_mc, 4);
        chk("frame.layer_avail", n_la[0] - b_la, 3);
        chk("frame.input_consume", n_ic[0] - b_ic, 3);
        chk("frame.frame_done", n_fd[0] - b_fd, 1);
        chk("frame.last_pos", last_pos[0], 11);
        chk("frame.busy_after", o[0].busy, 0);
        chk("frame.no_spurious", o[0].sp, 0);

        // Input withheld between steps: hold in WAIT_IN, resume one cycle after it returns
        step();
        av[0] = 1'b1;
        wait_ev(0, 0, 1000);
        av[0] = 1'b0;
        b_ls = n_ls[0];
        repeat (10) step();
        samp();
        chk("hold.starts", n_ls[0] - b_ls, 0);
        chk("hold.ts_idx", o[0].ts, 1);
        chk("hold.busy", o[0].busy, 1);
        step();
        av[0] = 1'b1;
        step();
        samp();
        chk("resume.layer_start", o[0].ls, 1);
        chk("resume.mem_clear", o[0].mc, 0);
        step();
        wait_ev(0, 1, 1000);
        av[0] = 1'b0;

        // Stray done in IDLE, then in WAIT_IN
        inj[0] = 1'b1;
        step();
        inj[0] = 1'b0;
        samp();
        chk("stray_idle.spurious", o[0].sp, 1);
        chk("stray_idle.busy", o[0].busy, 0);
        step();
        av[0] = 1'b1;
        wait_ev(0, 0, 1000);
        av[0] = 1'b0;
        b_ls = n_ls[0];
        inj[0] = 1'b1;
        step();
        inj[0] = 1'b0;
        repeat (3) step();
        samp();
        chk("stray_wait.spurious", o[0].sp, 1);
        chk("stray_wait.ts_idx", o[0].ts, 1);
        chk("stray_wait.oc_grp", o[0].grp, 0);
        chk("stray_wait.starts", n_ls[0] - b_ls, 0);
        step();
        av[0] = 1'b1;
        wait_ev(0, 1, 1000);
        av[0] = 1'b0;

        // Reset while pass (1,2) is in flight
        step();
        b_hit = n_hit[0];
        av[0] = 1'b1;
        wait_ev(0, 2, 1000);
        chk("abort.hit", n_hit[0] - b_hit, 1);
        rs[0] = 1'b1;
        av[0] = 1'b0;
        step();
        rs[0] = 1'b0;
        samp();
        chk("abort.busy", o[0].busy, 0);
        chk("abort.ts_idx", o[0].ts, 0);
        chk("abort.oc_grp", o[0].grp, 0);
        chk("abort.frame_cycles", o[0].fc, 0);
        chk("abort.spurious", o[0].sp, 0);
        chk("abort.bank", o[0].bank, 0);
        repeat (4) step();
        samp();
        chk("abort.late_done", o[0].sp, 1);
        step();
        av[0] = 1'b1;
        step();
        samp();
        chk("restart.layer_start", o[0].ls, 1);
        chk("restart.mem_clear", o[0].mc, 1);
        chk("restart.ts_idx", o[0].ts, 0);
        chk("restart.oc_grp", o[0].grp, 0);
        step();
        wait_ev(0, 1, 1000);
        av[0] = 1'b0;

        // Two steps with back-to-back done
        step();
        b_ls = n_ls[1];
        av[1] = 1'b1;
        wait_ev(1, 1, 500);
        av[1] = 1'b0;
        samp();
        chk("fast.frame_cycles", o[1].fc, 20);
        chk("fast.starts", n_ls[1] - b_ls, 8);
        chk("fast.first_bank", first_bank[1], 0);
        chk("fast.last_bank", last_bank[1], 1);

        // Single step, slow done, 4-bit counter saturates
        step();
        b_ls = n_ls[2];
        b_mc = n_mc[2];
        av[2] = 1'b1;
        wait_ev(2, 1, 500);
        av[2] = 1'b0;
        samp();
        chk("sat.frame_cycles", o[2].fc, 15);
        chk("sat.starts", n_ls[2] - b_ls, 4);
        chk("sat.mem_clears", n_mc[2] - b_mc, 4);
        step();
        samp();
        chk("sat.held", o[2].fc, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
